control_unit: RTL

- Decode/control stage directly downstream of the instruction-fetch/PC block.
- Consumes the 24-bit Instr word and drives register-file, ALU and memory controls.
- Returns immediate[7:0] and PCSrc to the fetch stage, plus a stall (PC-hold) request.
- Holds sequential state: status flags, multi-cycle MUL sequencer, sticky HALT.

---
 rtl/ctrl_pkg.sv | 47 ++++
 rtl/mul_sequencer.sv | 28 ++
 rtl/control_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and field positions for the decode/control stage.
package ctrl_pkg;

  localparam int INSTR_W = 24;
  localparam int OP_MSB  = 23;
  localparam int OP_LSB  = 20;
  localparam int RD_MSB  = 19;
  localparam int RD_LSB  = 16;
  localparam int RS1_MSB = 15;
  localparam int RS1_LSB = 12;
  localparam int RS2_MSB = 11;
  localparam int RS2_LSB = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_ADDI = 4'h5,
    OP_LW   = 4'h6,
    OP_SW   = 4'h7,
    OP_BEQ  = 4'h8,
    OP_BNE  = 4'h9,
    OP_JMP  = 4'hA,
    OP_MUL  = 4'hB,
    OP_CMP  = 4'hC,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_MUL = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_HALTED   = 2'd2
  } state_e;

endpackage

// File: rtl/mul_sequencer.sv
// Cycle counter for a multi-cycle MUL: counts occupancy and flags the final cycle.
module mul_sequencer #(
  parameter int MUL_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic active,
  output logic last,
  output logic busy_stall
);
  import ctrl_pkg::*;

  localparam logic [3:0] LAST_CNT = 4'(MUL_CYCLES - 1);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           count <= 4'd0;
    else if (start)       count <= 4'd1;
    else if (last)        count <= 4'd0;
    else if (active)      count <= count + 4'd1;
  end

  assign last       = active && (count == LAST_CNT);
  assign busy_stall = active && !last;

endmodule

// File: rtl/control_unit.sv
// Decode/control stage: combinational decode, status flags, MUL sequencing, sticky HALT.
// Optional build macro CTRL_PERF_CNT_EN adds retired/stall performance counters.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int         MUL_CYCLES = 3,
  parameter logic [1:0] FLAG_RST   = 2'b00
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               alu_zero,
  input  logic               alu_neg,
  output logic [7:0]         immediate,
  output logic               PCSrc,
  output logic               stall,
  output logic               RegWrite,
  output logic               ALUSrc,
  output logic [2:0]         ALUOp,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic [3:0]         rd,
  output logic [3:0]         rs1,
  output logic [3:0]         rs2,
  output logic               flag_z,
  output logic               flag_n,
  output logic               halted,
  output logic               illegal
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [15:0]        retired_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  state_e  state, state_nxt;
  opcode_e op;
  logic    mul_start, retire, upd_flags;
  logic    seq_last, seq_stall;

  assign op        = opcode_e'(Instr[OP_MSB:OP_LSB]);
  assign rd        = Instr[RD_MSB:RD_LSB];
  assign rs1       = Instr[RS1_MSB:RS1_LSB];
  assign rs2       = Instr[RS2_MSB:RS2_LSB];
  assign immediate = Instr[IMM_MSB:IMM_LSB];

  mul_sequencer #(.MUL_CYCLES(MUL_CYCLES)) u_mul_seq (
    .clk        (CLK),
    .rst_n      (reset),
    .start      (mul_start),
    .active     (state == ST_MUL_BUSY),
    .last       (seq_last),
    .busy_stall (seq_stall)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)         {flag_n, flag_z} <= FLAG_RST;
    else if (upd_flags) {flag_n, flag_z} <= {alu_neg, alu_zero};
  end

  // Outputs are held low while reset is asserted, independent of decode.
  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    retire    = 1'b0;
    upd_flags = 1'b0;
    PCSrc     = 1'b0;
    stall     = 1'b0;
    RegWrite  = 1'b0;
    ALUSrc    = 1'b0;
    ALUOp     = ALU_ADD;
    MemWrite  = 1'b0;
    MemToReg  = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    if (reset) begin
      case (state)
        ST_HALTED: begin
          halted = 1'b1;
          stall  = 1'b1;
        end
        ST_MUL_BUSY: begin
          ALUOp = ALU_MUL;
          stall = seq_stall;
          if (seq_last) begin
            RegWrite  = 1'b1;
            retire    = 1'b1;
            upd_flags = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_IDLE: begin
          retire = 1'b1;
          case (op)
            OP_NOP: ;
            OP_ADD:  begin RegWrite = 1'b1; upd_flags = 1'b1; end
            OP_SUB:  begin RegWrite = 1'b1; ALUOp = ALU_SUB; upd_flags = 1'b1; end
            OP_AND:  begin RegWrite = 1'b1; ALUOp = ALU_AND; upd_flags = 1'b1; end
            OP_OR:   begin RegWrite = 1'b1; ALUOp = ALU_OR;  upd_flags = 1'b1; end
            OP_ADDI: begin RegWrite = 1'b1; ALUSrc = 1'b1;   upd_flags = 1'b1; end
            OP_LW:   begin RegWrite = 1'b1; ALUSrc = 1'b1; MemToReg = 1'b1; end
            OP_SW:   begin MemWrite = 1'b1; ALUSrc = 1'b1; end
            OP_BEQ:  PCSrc = flag_z;
            OP_BNE:  PCSrc = !flag_z;
            OP_JMP:  PCSrc = 1'b1;
            OP_CMP:  begin ALUOp = ALU_SUB; upd_flags = 1'b1; end
            OP_MUL: begin
              ALUOp = ALU_MUL;
              if (MUL_CYCLES > 1) begin
                stall     = 1'b1;
                retire    = 1'b0;
                mul_start = 1'b1;
                state_nxt = ST_MUL_BUSY;
              end else begin
                RegWrite  = 1'b1;
                upd_flags = 1'b1;
              end
            end
            OP_HALT: begin
              stall     = 1'b1;
              retire    = 1'b0;
              state_nxt = ST_HALTED;
            end
            default: illegal = 1'b1;
          endcase
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      retired_cnt <= 16'd0;
      stall_cnt   <= 16'd0;
    end else begin
      if (retire && retired_cnt != 16'hFFFF)
        retired_cnt <= retired_cnt + 16'd1;
      if (stall && state != ST_HALTED && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
